// File: rtl/imem_debug_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory debug loader.
// Latency: n/a (declarations only).
// Backpressure: n/a. IMEM_LOADER_CHECKSUM_EN adds the CHECK state encoding.
package imem_debug_loader_pkg;

    localparam int IMEM_NB_INST   = 32;
    localparam int IMEM_NB_ADDR   = 8;
    localparam int IMEM_MEM_DEPTH = 256;

    // UART command bytes
    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_RUN  = 8'h43;  // 'C'
    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
    localparam logic [7:0] CMD_NEXT = 8'h4E;  // 'N'

    // Word that terminates a program image
    localparam logic [31:0] HALT_WORD = 32'hFC000000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_RUN    = 3'd3,
        ST_STEP   = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_HALTED = 3'd5,
        ST_CHECK  = 3'd6
`else
        ST_HALTED = 3'd5
`endif
    } state_e;

endpackage

// File: rtl/imem_debug_loader_word_assembler.sv
// Packs UART bytes MSB-first into 32-bit words; word_vld fires combinationally with the 4th byte.
// Latency: 0 cycles from 4th byte strobe to o_word_vld (word = 3 stored bytes + current byte).
// Backpressure: none; every strobed byte is taken while i_en is high.
module imem_debug_loader_word_assembler (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte_dat,
    output logic [31:0] o_word,
    output logic        o_word_vld
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    // Shift in accepted bytes and count them; the count wraps to 0 after the 4th byte
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (i_clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (i_en && i_byte_vld) begin
            shift_d = {shift_q[15:0], i_byte_dat};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    // Byte shift register and counter
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_word     = {shift_q, i_byte_dat};
    assign o_word_vld = i_en && i_byte_vld && !i_clear && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_debug_loader.sv
// UART-driven program loader for the FETCH debug port, then run / single-step / halt control.
// Latency: all outputs registered; 4th byte of a word -> o_mem_wen one cycle later.
// Backpressure: none; bytes outside accepting states are dropped. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module imem_debug_loader
    import imem_debug_loader_pkg::*;
#(
    parameter int NB_INST   = IMEM_NB_INST,
    parameter int NB_ADDR   = IMEM_NB_ADDR,
    parameter int MEM_DEPTH = IMEM_MEM_DEPTH
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx_valid,
    input  logic [7:0]         i_rx_data,
    input  logic               i_halt,
    output logic               o_debug_unit,
    output logic               o_mem_wen,
    output logic               o_mem_ren,
    output logic [NB_INST-1:0] o_mem_data,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic               o_enable_pipe,
    output logic               o_pipe_clear,
    output logic               o_load_done,
    output logic               o_error
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEM_DEPTH - 1);
    localparam logic [NB_INST-1:0] HALT_INST = NB_INST'(HALT_WORD);

    state_e             state_q, state_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [NB_INST-1:0] data_q, data_d;
    logic               mem_wen_q, mem_wen_d;
    logic               pipe_clear_q, pipe_clear_d;
    logic               enable_pipe_q, enable_pipe_d;
    logic               load_done_q, load_done_d;
    logic               error_q, error_d;
    logic               debug_unit_q, debug_unit_d;
    logic               mem_ren_q, mem_ren_d;

    logic               asm_clear;
    logic               asm_en;
    logic [31:0]        asm_word;
    logic               asm_word_vld;
    logic               run_allowed;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         chk_q, chk_d;
    logic               chk_match;
    assign chk_match   = (i_rx_data == chk_q);
    // A failed image must be reloaded before the pipeline may be released
    assign run_allowed = !error_q;
`else
    assign run_allowed = 1'b1;
`endif

    imem_debug_loader_word_assembler u_word_asm (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_clear    (asm_clear),
        .i_en       (asm_en),
        .i_byte_vld (i_rx_valid),
        .i_byte_dat (i_rx_data),
        .o_word     (asm_word),
        .o_word_vld (asm_word_vld)
    );

    // Next-state and registered-output computation for the loader/run-control FSM
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        mem_wen_d     = 1'b0;
        pipe_clear_d  = 1'b0;
        enable_pipe_d = 1'b0;
        load_done_d   = load_done_q;
        error_d       = error_q;
        asm_clear     = 1'b0;
        asm_en        = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d         = chk_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_STEP, ST_HALTED: begin
                if ((state_q == ST_STEP) && i_halt) begin
                    // Halt beats a coincident 'N'
                    state_d = ST_HALTED;
                end else if (i_rx_valid) begin
                    if (i_rx_data == CMD_LOAD) begin
                        pipe_clear_d = 1'b1;
                        addr_d       = '0;
                        load_done_d  = 1'b0;
                        error_d      = 1'b0;
                        asm_clear    = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_d        = '0;
`endif
                        state_d      = ST_LOAD;
                    end else if (((i_rx_data == CMD_RUN) || (i_rx_data == CMD_STEP)) && run_allowed) begin
                        // Leaving STEP keeps the pipeline state; fresh starts clear it
                        pipe_clear_d = (state_q != ST_STEP);
                        state_d      = (i_rx_data == CMD_RUN) ? ST_RUN : ST_STEP;
                    end else if ((i_rx_data == CMD_NEXT) && (state_q == ST_STEP)) begin
                        enable_pipe_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                asm_en = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (i_rx_valid) begin
                    chk_d = chk_q ^ i_rx_data;
                end
`endif
                if (asm_word_vld) begin
                    data_d    = NB_INST'(asm_word);
                    mem_wen_d = 1'b1;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (data_q == HALT_INST) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    // A byte landing in this cycle is already the check byte
                    if (i_rx_valid) begin
                        load_done_d = chk_match;
                        error_d     = !chk_match;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d     = ST_CHECK;
                    end
`else
                    load_done_d = 1'b1;
                    state_d     = ST_IDLE;
`endif
                end else if (addr_q == LAST_ADDR) begin
                    // Image larger than memory: stop, no wrap-around
                    error_d     = 1'b1;
                    load_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    // Keep assembling so a byte arriving now becomes byte 0 of the next word
                    asm_en  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (i_rx_valid) begin
                        chk_d = chk_q ^ i_rx_data;
                    end
`endif
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (i_halt) begin
                    state_d = ST_HALTED;
                end else begin
                    enable_pipe_d = 1'b1;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (i_rx_valid) begin
                    load_done_d = chk_match;
                    error_d     = !chk_match;
                    state_d     = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Memory belongs to the pipeline whenever it is running, stepping or halted for readout
        debug_unit_d = !((state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_HALTED));
        mem_ren_d    = !debug_unit_d;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            data_q        <= '0;
            mem_wen_q     <= 1'b0;
            pipe_clear_q  <= 1'b0;
            enable_pipe_q <= 1'b0;
            load_done_q   <= 1'b0;
            error_q       <= 1'b0;
            debug_unit_q  <= 1'b1;
            mem_ren_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            mem_wen_q     <= mem_wen_d;
            pipe_clear_q  <= pipe_clear_d;
            enable_pipe_q <= enable_pipe_d;
            load_done_q   <= load_done_d;
            error_q       <= error_d;
            debug_unit_q  <= debug_unit_d;
            mem_ren_q     <= mem_ren_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q         <= chk_d;
`endif
        end
    end

    assign o_debug_unit  = debug_unit_q;
    assign o_mem_wen     = mem_wen_q;
    assign o_mem_ren     = mem_ren_q;
    assign o_mem_data    = data_q;
    assign o_wr_addr     = addr_q;
    assign o_enable_pipe = enable_pipe_q;
    assign o_pipe_clear  = pipe_clear_q;
    assign o_load_done   = load_done_q;
    assign o_error       = error_q;

endmodule

// File: tb/tb_imem_debug_loader.sv
// Directed-plus-random bench for imem_debug_loader against a behavioural program-image model.
// Latency: inputs driven 1 time unit after posedge, outputs sampled then or at negedge.
// Backpressure: none; covers IMEM_LOADER_CHECKSUM_EN when that macro is defined.
module tb_imem_debug_loader;

    logic        i_clock    = 1'b0;
    logic        i_reset    = 1'b0;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  i_rx_data  = 8'h00;
    logic        i_halt     = 1'b0;
    logic        o_debug_unit;
    logic        o_mem_wen;
    logic        o_mem_ren;
    logic [31:0] o_mem_data;
    logic [7:0]  o_wr_addr;
    logic        o_enable_pipe;
    logic        o_pipe_clear;
    logic        o_load_done;
    logic        o_error;

    imem_debug_loader dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_rx_valid    (i_rx_valid),
        .i_rx_data     (i_rx_data),
        .i_halt        (i_halt),
        .o_debug_unit  (o_debug_unit),
        .o_mem_wen     (o_mem_wen),
        .o_mem_ren     (o_mem_ren),
        .o_mem_data    (o_mem_data),
        .o_wr_addr     (o_wr_addr),
        .o_enable_pipe (o_enable_pipe),
        .o_pipe_clear  (o_pipe_clear),
        .o_load_done   (o_load_done),
        .o_error       (o_error)
    );

    always #5 i_clock = ~i_clock;

    localparam logic [31:0] HALT = 32'hFC000000;

    int checks = 0;
    int errors = 0;

    // Observation log, only ever written by the monitor
    logic [39:0] wr_log[$];
    int          clear_cnt  = 0;
    int          en_cycles  = 0;
    int          en_pulses  = 0;
    logic        en_prev    = 1'b0;

    always @(negedge i_clock) begin
        if (o_mem_wen === 1'b1) wr_log.push_back({o_wr_addr, o_mem_data});
        if (o_pipe_clear === 1'b1) clear_cnt++;
        if (o_enable_pipe === 1'b1) en_cycles++;
        if (o_enable_pipe === 1'b1 && en_prev !== 1'b1) en_pulses++;
        en_prev = o_enable_pipe;
    end

    logic [31:0] prog[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(posedge i_clock);
        #1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'($urandom);
    endtask

    task automatic send_words(input int n, output logic [7:0] xsum);
        logic [31:0] w;
        xsum = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = prog[i];
            for (int k = 3; k >= 0; k--) begin
                idle(int'($urandom_range(0, 2)));
                send_byte(w[8*k +: 8]);
                xsum = xsum ^ w[8*k +: 8];
            end
        end
    endtask

    // Model: the image is written from address 0 up to and including the first HALT;
    // without a HALT inside the memory depth the load stops after address 255 with error.
    task automatic run_load(input string tag);
        int          base;
        int          n_exp;
        int          got;
        logic        exp_err;
        logic [7:0]  xsum;
        logic [39:0] exp_ent;
        base    = wr_log.size();
        n_exp   = 0;
        exp_err = 1'b1;
        foreach (prog[i]) begin
            if (n_exp < 256 && exp_err) begin
                n_exp++;
                if (prog[i] == HALT) exp_err = 1'b0;
            end
        end
        send_byte(8'h4C);
        check({tag, " clear_pulse"}, 64'(o_pipe_clear), 64'(1));
        check({tag, " done_cleared"}, 64'(o_load_done), 64'(0));
        check({tag, " err_cleared"}, 64'(o_error), 64'(0));
        send_words(n_exp, xsum);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (!exp_err) begin
            idle(int'($urandom_range(0, 2)));
            send_byte(xsum);
        end
`endif
        idle(4);
        got = wr_log.size() - base;
        check({tag, " n_writes"}, 64'(got), 64'(n_exp));
        for (int i = 0; i < n_exp && i < got; i++) begin
            exp_ent = {i[7:0], prog[i]};
            check({tag, " write"}, 64'(wr_log[base + i]), 64'(exp_ent));
        end
        check({tag, " load_done"}, 64'(o_load_done), 64'(1));
        check({tag, " error"}, 64'(o_error), 64'(exp_err));
        check({tag, " debug_unit"}, 64'(o_debug_unit), 64'(1));
        check({tag, " mem_ren"}, 64'(o_mem_ren), 64'(0));
    endtask

    initial begin
        int          cb;
        int          ec;
        int          ep;
        int          run_len;
        int          nbase;
        logic [31:0] w;
        logic [7:0]  xsum;

        // Reset held low for three cycles
        idle(3);
        check("rst debug_unit", 64'(o_debug_unit), 64'(1));
        check("rst mem_ren", 64'(o_mem_ren), 64'(0));
        check("rst enable", 64'(o_enable_pipe), 64'(0));
        check("rst mem_wen", 64'(o_mem_wen), 64'(0));
        check("rst error", 64'(o_error), 64'(0));
        check("rst load_done", 64'(o_load_done), 64'(0));
        check("rst pipe_clear", 64'(o_pipe_clear), 64'(0));
        i_reset = 1'b1;
        idle(2);

        // Fixed two-word program
        prog.delete();
        prog.push_back(32'h3C01000A);
        prog.push_back(HALT);
        run_load("fixed");

        // 256 non-HALT words: fills memory and flags overflow
        prog.delete();
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            if (w == HALT) w = w ^ 32'h1;
            prog.push_back(w);
        end
        run_load("overflow");
        nbase = wr_log.size();
        idle(12);
        check("overflow no_wrap", 64'(wr_log.size()), 64'(nbase));
        check("overflow addr_held", 64'(o_wr_addr), 64'(255));

        // Short random program, also shows error is cleared by the next load
        prog.delete();
        for (int i = 0; i < int'($urandom_range(3, 8)); i++) begin
            w = $urandom;
            if (w == HALT) w = w ^ 32'h1;
            prog.push_back(w);
        end
        prog.push_back(HALT);
        run_load("random");

        // Reset in the middle of a load
        send_byte(8'h4C);
        prog.delete();
        prog.push_back(32'h12345678);
        prog.push_back(32'h9ABCDEF0);
        send_words(1, xsum);
        send_byte(8'h9A);
        i_reset = 1'b0;
        idle(3);
        check("midrst load_done", 64'(o_load_done), 64'(0));
        check("midrst debug_unit", 64'(o_debug_unit), 64'(1));
        check("midrst wr_addr", 64'(o_wr_addr), 64'(0));
        i_reset = 1'b1;
        idle(2);
        prog.delete();
        prog.push_back(32'h20010005);
        prog.push_back(32'h00000000);
        prog.push_back(HALT);
        run_load("reload");

        // Continuous run, bytes ignored while running, halt after a random time
        cb = clear_cnt;
        ec = en_cycles;
        send_byte(8'h43);
        check("run clear_pulse", 64'(o_pipe_clear), 64'(1));
        check("run debug_unit", 64'(o_debug_unit), 64'(0));
        check("run mem_ren", 64'(o_mem_ren), 64'(1));
        check("run enable_late", 64'(o_enable_pipe), 64'(0));
        run_len = int'($urandom_range(19, 30));
        for (int i = 0; i < run_len; i++) begin
            if (i == 4) send_byte(8'h4C);
            else idle(1);
        end
        i_halt = 1'b1;
        idle(1);
        i_halt = 1'b0;
        check("halt enable_off", 64'(o_enable_pipe), 64'(0));
        check("halt debug_unit", 64'(o_debug_unit), 64'(0));
        idle(3);
        check("run enable_cycles", 64'(en_cycles - ec), 64'(run_len));
        check("run one_clear", 64'(clear_cnt - cb), 64'(1));

        // Single step from HALTED
        cb = clear_cnt;
        send_byte(8'h53);
        check("step clear_pulse", 64'(o_pipe_clear), 64'(1));
        check("step debug_unit", 64'(o_debug_unit), 64'(0));
        idle(3);
        check("step idle_enable", 64'(o_enable_pipe), 64'(0));
        ec = en_cycles;
        ep = en_pulses;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h4E);
            check("step pulse_on", 64'(o_enable_pipe), 64'(1));
            idle(int'($urandom_range(1, 3)));
        end
        idle(2);
        check("step pulses", 64'(en_pulses - ep), 64'(3));
        check("step cycles", 64'(en_cycles - ec), 64'(3));
        i_halt = 1'b1;
        send_byte(8'h4E);
        i_halt = 1'b0;
        check("step halt_wins", 64'(o_enable_pipe), 64'(0));
        send_byte(8'h4E);
        idle(3);
        check("step halted_pulses", 64'(en_pulses - ep), 64'(3));
        check("step halted_debug", 64'(o_debug_unit), 64'(0));
        check("step clears", 64'(clear_cnt - cb), 64'(1));

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum byte: error set, done clear, run commands refused
        prog.delete();
        prog.push_back(32'h3C01000A);
        prog.push_back(HALT);
        send_byte(8'h4C);
        send_words(2, xsum);
        idle(2);
        send_byte(xsum ^ 8'h01);
        idle(2);
        check("chk bad error", 64'(o_error), 64'(1));
        check("chk bad done", 64'(o_load_done), 64'(0));
        send_byte(8'h43);
        check("chk run_refused", 64'(o_debug_unit), 64'(1));
        check("chk no_clear", 64'(o_pipe_clear), 64'(0));
        run_load("chk good");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
